// File: rtl/aes_req_arb.sv
// rtl/aes_req_arb.sv - two-requester arbiter sharing one AES block engine with in-order result return
//
// Build option: define AES_ARB_STRICT_PRIO_EN for fixed priority (port 0 always wins,
// no round-robin pointer). Default build is round-robin.
//
// aes_arb_tag_fifo ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_tag    write one owner tag (caller guarantees room, counting a same-cycle pop)
//   pop               retire the head tag (caller guarantees not empty)
//   head_tag          owner of the oldest outstanding block
//   full, empty       occupancy flags
//   count             number of stored tags
//
// aes_req_arb ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   s0_*, s1_*                  requester block inputs (data/vld/rdy)
//   m_data, m_vld, m_rdy        registered block issue towards the engine
//   e_data, e_vld, e_rdy        engine result input
//   r0_*, r1_*                  per-requester result outputs (data/vld/rdy)
//   outstanding                 blocks issued whose result has not returned
//   err                         sticky: result seen while no block was outstanding

module aes_arb_tag_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   push_tag,
  input  logic                   pop,
  output logic                   head_tag,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [DEPTH-1:0] tags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      tags <= '0;
    end else begin
      // When full and popping in the same cycle the write lands on the head
      // slot, which is being retired, so the overwrite is harmless.
      if (push) begin
        tags[wptr[AW-1:0]] <= push_tag;
        wptr               <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  // Extra MSB on the pointers separates full (MSBs differ) from empty (equal).
  assign count    = wptr - rptr;
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head_tag = tags[rptr[AW-1:0]];

endmodule

module aes_req_arb #(
  parameter int DATA_W    = 128,
  parameter int TAG_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          s0_data,
  input  logic                       s0_vld,
  output logic                       s0_rdy,
  input  logic [DATA_W-1:0]          s1_data,
  input  logic                       s1_vld,
  output logic                       s1_rdy,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_vld,
  input  logic                       m_rdy,
  input  logic [DATA_W-1:0]          e_data,
  input  logic                       e_vld,
  output logic                       e_rdy,
  output logic [DATA_W-1:0]          r0_data,
  output logic                       r0_vld,
  input  logic                       r0_rdy,
  output logic [DATA_W-1:0]          r1_data,
  output logic                       r1_vld,
  input  logic                       r1_rdy,
  output logic [$clog2(TAG_DEPTH):0] outstanding,
  output logic                       err
);

  logic load_ok;
  logic fifo_full;
  logic fifo_empty;
  logic head_tag;
  logic pop;
  logic can_issue;
  logic gnt0;
  logic gnt1;
  logic accept;

  aes_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept),
    .push_tag (gnt1),
    .pop      (pop),
    .head_tag (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (outstanding)
  );

  // Return routing: the head tag names the owner of the result on e_*.
  // With nothing outstanding the result is a protocol error: swallow it.
  always_comb begin
    r0_vld = 1'b0;
    r1_vld = 1'b0;
    e_rdy  = 1'b0;
    if (fifo_empty) begin
      e_rdy = e_vld;
    end else if (head_tag) begin
      r1_vld = e_vld;
      e_rdy  = r1_rdy;
    end else begin
      r0_vld = e_vld;
      e_rdy  = r0_rdy;
    end
  end

  assign r0_data = e_data;
  assign r1_data = e_data;
  assign pop     = e_vld && e_rdy && !fifo_empty;

  // A full tag FIFO still accepts when a result retires in the same cycle,
  // so a full engine pipeline keeps streaming at one block per cycle.
  assign load_ok   = !m_vld || m_rdy;
  assign can_issue = load_ok && (!fifo_full || pop);

`ifdef AES_ARB_STRICT_PRIO_EN
  assign gnt0 = can_issue && s0_vld;
  assign gnt1 = can_issue && s1_vld && !s0_vld;
`else
  // rr remembers the last granted port; on contention the other port wins.
  logic rr;

  assign gnt0 = can_issue && s0_vld && (!s1_vld || rr);
  assign gnt1 = can_issue && s1_vld && (!s0_vld || !rr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= 1'b1;
    end else if (accept) begin
      rr <= gnt1;
    end
  end
`endif

  assign s0_rdy = gnt0;
  assign s1_rdy = gnt1;
  assign accept = gnt0 || gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld  <= 1'b0;
      m_data <= '0;
      err    <= 1'b0;
    end else begin
      if (accept) begin
        m_vld  <= 1'b1;
        m_data <= gnt1 ? s1_data : s0_data;
      end else if (m_rdy) begin
        m_vld <= 1'b0;
      end
      if (e_vld && fifo_empty) begin
        err <= 1'b1;
      end
    end
  end

endmodule
